// File: rtl/seg_anim_pkg.sv
// Shared state type and 7-segment encoding for the scrolling hex display.
package seg_anim_pkg;

    typedef enum logic {IDLE, DRAW} state_e;

    // Segment bit positions, active-high, gfedcba ordering
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [SEG_G:SEG_A] SEG_ALL = 7'h7F;

    // Entry n is the pattern for hex digit n
    localparam logic [15:0][SEG_G:SEG_A] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex nibble to 7-segment pattern lookup.
module hex7seg_decoder
    import seg_anim_pkg::*;
(
    input  logic [3:0]         nibble_i,
    output logic [SEG_G:SEG_A] seg_o
);

    always_comb begin
        seg_o = HEX_SEG_TABLE[nibble_i];
    end

endmodule

// File: rtl/seg_scroll_animator.sv
// Character FIFO feeding a scrolling, frame-animated multiplexed 7-segment display.
// Define SEG_SCROLL_ANIM_EN for the segment-by-segment draw-in; otherwise digits appear whole.
module seg_scroll_animator
    import seg_anim_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MUX_DIV    = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ena,
    input  logic                          frame_tick,
    input  logic                          char_valid,
    input  logic [3:0]                    char_in,
    output logic                          char_ready,
    output logic [6:0]                    seg,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned DW = $clog2(MUX_DIV);

    // ---------------- character FIFO ----------------
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;
    state_e        state_q;

    assign char_ready = ena && !reset && (count_q < CW'(FIFO_DEPTH));
    assign push       = char_valid && char_ready;
    assign pop        = ena && (state_q == IDLE) && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= char_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    logic [SEG_G:SEG_A] head_seg;

    hex7seg_decoder u_head_dec (
        .nibble_i (mem_q[rd_ptr_q]),
        .seg_o    (head_seg)
    );

    // ---------------- display register and draw FSM ----------------
    logic [SEG_G:SEG_A] disp_q [NUM_DIGITS];
    logic [SEG_G:SEG_A] mask_q;
`ifdef SEG_SCROLL_ANIM_EN
    logic [2:0]         step_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                disp_q[i] <= '0;
            end
            mask_q  <= SEG_ALL;
            state_q <= IDLE;
`ifdef SEG_SCROLL_ANIM_EN
            step_q  <= '0;
`endif
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
                            disp_q[i] <= disp_q[i-1];
                        end
                        disp_q[0] <= head_seg;
                        mask_q    <= '0;
`ifdef SEG_SCROLL_ANIM_EN
                        step_q    <= '0;
`endif
                        state_q   <= DRAW;
                    end
                end
                DRAW: begin
                    if (frame_tick) begin
`ifdef SEG_SCROLL_ANIM_EN
                        step_q <= step_q + 3'd1;
                        if (step_q == 3'd6) begin
                            mask_q  <= SEG_ALL;
                            state_q <= IDLE;
                        end else begin
                            mask_q[step_q] <= 1'b1;
                        end
`else
                        mask_q  <= SEG_ALL;
                        state_q <= IDLE;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = !reset && ((state_q == DRAW) || (count_q != '0));
    assign fifo_count = count_q;

    // ---------------- digit scan ----------------
    logic [DW-1:0]         div_q;
    logic [IW-1:0]         idx_q;
    logic [SEG_G:SEG_A]    seg_d;
    logic [SEG_G:SEG_A]    seg_q;
    logic [NUM_DIGITS-1:0] sel_d;
    logic [NUM_DIGITS-1:0] sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (ena) begin
            if (div_q == DW'(MUX_DIV - 1)) begin
                div_q <= '0;
                idx_q <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    // Only the newest digit is masked while it draws in
    always_comb begin
        seg_d        = (idx_q == '0) ? (disp_q[0] & mask_q) : disp_q[idx_q];
        sel_d        = '0;
        sel_d[idx_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= '0;
            sel_q <= NUM_DIGITS'(1);
        end else begin
            seg_q <= seg_d;
            sel_q <= sel_d;
        end
    end

    assign seg       = seg_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_seg_scroll_animator.sv
// Self-checking bench for seg_scroll_animator against a queue-based behavioural model.
module tb_seg_scroll_animator;

    localparam int ND = 4;
    localparam int FD = 8;
    localparam int MD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic       frame_tick;
    logic       char_valid;
    logic [3:0] char_in;
    logic       char_ready;
    logic [6:0] seg;
    logic [ND-1:0] digit_sel;
    logic       busy;
    logic [3:0] fifo_count;

    always #5 clk = ~clk;

    seg_scroll_animator #(
        .NUM_DIGITS (ND),
        .FIFO_DEPTH (FD),
        .MUX_DIV    (MD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .frame_tick (frame_tick),
        .char_valid (char_valid),
        .char_in    (char_in),
        .char_ready (char_ready),
        .seg        (seg),
        .digit_sel  (digit_sel),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [6:0] hex_tbl [16];

    // Model: FIFO as a queue, display as an array, reveal as a count of lit segments
    int q[$];
    int m_disp [ND];
    int m_rev;
    bit m_drawing;
    int m_en_cycles;
    int exp_seg;
    int exp_sel;

    function automatic int mask_of(int k);
        return (k >= 7) ? 127 : ((1 << k) - 1);
    endfunction

    function automatic int shown(int i);
        return (i == 0) ? (m_disp[0] & mask_of(m_rev)) : m_disp[i];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        int idx;
        int c;
        bit acc;
        bit popm;
        if (reset) begin
            q.delete();
            for (int i = 0; i < ND; i++) m_disp[i] = 0;
            m_rev = 7;
            m_drawing = 0;
            m_en_cycles = 0;
            exp_seg = 0;
            exp_sel = 1;
            return;
        end
        idx = (m_en_cycles / MD) % ND;
        exp_seg = shown(idx);
        exp_sel = 1 << idx;
        acc  = char_valid && ena && (q.size() < FD);
        popm = ena && !m_drawing && (q.size() > 0);
        if (popm) begin
            c = q.pop_front();
            for (int i = ND - 1; i > 0; i--) m_disp[i] = m_disp[i-1];
            m_disp[0] = hex_tbl[c];
            m_rev = 0;
            m_drawing = 1;
        end else if (m_drawing && ena && frame_tick) begin
`ifdef SEG_SCROLL_ANIM_EN
            m_rev++;
`else
            m_rev = 7;
`endif
            if (m_rev >= 7) m_drawing = 0;
        end
        if (acc) q.push_back(int'(char_in));
        if (ena) m_en_cycles++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("seg", seg, exp_seg);
        chk("digit_sel", digit_sel, exp_sel);
        chk("fifo_count", fifo_count, q.size());
        chk("busy", busy, (!reset && (m_drawing || q.size() > 0)) ? 1 : 0);
        chk("char_ready", char_ready, (ena && !reset && q.size() < FD) ? 1 : 0);
    endtask

    task automatic idle(int n);
        char_valid = 1'b0;
        frame_tick = 1'b0;
        repeat (n) step();
    endtask

    task automatic tick();
        char_valid = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic push_char(logic [3:0] c);
        bit done = 0;
        char_valid = 1'b1;
        char_in    = c;
        for (int k = 0; k < 200 && !done; k++) begin
            done = ena && (q.size() < FD);
            step();
        end
        char_valid = 1'b0;
        chk("push_accepted", done, 1);
    endtask

    task automatic wait_digit(int d, string tag, int expv);
        bit seen = 0;
        char_valid = 1'b0;
        frame_tick = 1'b0;
        for (int k = 0; k < 4 * ND * MD && !seen; k++) begin
            if (digit_sel == ND'(1 << d)) seen = 1;
            else step();
        end
        chk({tag, "_seen"}, seen, 1);
        if (seen) chk(tag, seg, expv);
    endtask

    task automatic finish_draw();
        repeat (7) begin
            tick();
            idle(1);
        end
    endtask

    logic [6:0] anim_seq [7];
    logic [3:0] chars [10];
    int cnt_before;

    initial begin
        hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef SEG_SCROLL_ANIM_EN
        anim_seq = '{7'h00, 7'h02, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};
`else
        anim_seq = '{7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};
`endif
        reset = 1'b1; ena = 1'b1; frame_tick = 1'b0; char_valid = 1'b0; char_in = '0;

        // Reset then idle scan
        step();
        step();
        chk("rst_seg", seg, 0);
        chk("rst_sel", digit_sel, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", char_ready, 0);
        chk("rst_count", fifo_count, 0);
        reset = 1'b0;
        idle(3 * ND * MD);
        chk("idle_busy", busy, 0);

        // Single char draw-in
        push_char(4'h1);
        idle(1);
        for (int k = 0; k < 7; k++) begin
            tick();
            idle(1);
            wait_digit(0, "anim_d0", anim_seq[k]);
        end
        idle(2);
        chk("anim_done_busy", busy, 0);

        // Two chars scroll
        push_char(4'hA);
        idle(1);
        finish_draw();
        push_char(4'h3);
        idle(1);
        tick(); tick(); tick();
        idle(1);
        wait_digit(1, "scroll_d1_mid", 7'h77);
        finish_draw();
        wait_digit(0, "scroll_d0", 7'h4F);
        wait_digit(1, "scroll_d1", 7'h77);

        // Back-to-back fill with frame_tick low
        for (int i = 0; i < 10; i++) chars[i] = 4'($urandom);
        frame_tick = 1'b0;
        for (int i = 0; i < 9; i++) begin
            char_valid = 1'b1;
            char_in    = chars[i];
            step();
        end
        chk("fill_count", fifo_count, 8);
        char_in = chars[9];
        repeat (5) step();
        chk("full_ready", char_ready, 0);
        chk("full_count", fifo_count, 8);
        char_valid = 1'b0;
        finish_draw();
        push_char(chars[9]);
        for (int k = 0; k < 200 && (m_drawing || q.size() > 0); k++) begin
            tick();
            idle(1);
        end
        idle(2);
        chk("drain_busy", busy, 0);
        wait_digit(0, "retry_d0", hex_tbl[chars[9]]);
        wait_digit(1, "retry_d1", hex_tbl[chars[8]]);
        wait_digit(3, "retry_d3", hex_tbl[chars[6]]);

        // Freeze with ena low mid-draw
        push_char(4'h2);
        idle(1);
        tick(); tick();
        cnt_before = q.size();
        ena = 1'b0;
        for (int k = 0; k < 100; k++) begin
            frame_tick = 1'($urandom);
            char_valid = 1'($urandom);
            char_in    = 4'($urandom);
            step();
        end
        chk("freeze_count", fifo_count, cnt_before);
        ena = 1'b1;
        char_valid = 1'b0;
        frame_tick = 1'b0;
        finish_draw();
        wait_digit(0, "resume_d0", 7'h5B);

        // Randomised traffic
        for (int k = 0; k < 600; k++) begin
            ena        = ($urandom_range(0, 9) != 0);
            char_valid = 1'($urandom);
            char_in    = 4'($urandom);
            frame_tick = ($urandom_range(0, 3) == 0);
            step();
        end
        ena = 1'b1;
        idle(2);

        // Reset during DRAW
        for (int k = 0; k < 200 && (m_drawing || q.size() > 0); k++) begin
            tick();
            idle(1);
        end
        push_char(4'h5);
        idle(1);
        tick(); tick();
        reset = 1'b1;
        step();
        chk("rst_draw_busy", busy, 0);
        chk("rst_draw_seg", seg, 0);
        reset = 1'b0;
        idle(2);
        wait_digit(0, "rst_draw_d0", 7'h00);
        wait_digit(1, "rst_draw_d1", 7'h00);

        // One tick on a fresh 8
        push_char(4'h8);
        idle(1);
        tick();
        idle(1);
`ifdef SEG_SCROLL_ANIM_EN
        wait_digit(0, "one_tick_d0", 7'h01);
`else
        wait_digit(0, "one_tick_d0", 7'h7F);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
